// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for port B of a 16K x 8 block memory, with locked
// bursts and a fixed-latency, requester-tagged read return pipeline.
module mem_port_arbiter #(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        sysclk,
  input  logic        arduino_reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic        r0_lock,
  input  logic [13:0] r0_ad,
  input  logic [7:0]  r0_din,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [7:0]  r0_dout,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic        r1_lock,
  input  logic [13:0] r1_ad,
  input  logic [7:0]  r1_din,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [7:0]  r1_dout,
  output logic        mem_clk,
  output logic        mem_ce,
  output logic        mem_oce,
  output logic        mem_wre,
  output logic [13:0] mem_ad,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  localparam int unsigned CntW = $clog2(BURST_MAX + 1);
  localparam logic [CntW-1:0] BurstMaxC = CntW'(BURST_MAX);

  logic              r_last_winner;
  logic              r_owner_valid;
  logic              r_owner_id;
  logic [CntW-1:0]   r_burst_cnt;
  logic [13:0]       r_ad_hold;
  logic [7:0]        r_din_hold;
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_id;

  logic              w_win;
  logic              w_grant;
  logic              w_win_we;
  logic              w_win_lock;
  logic [13:0]       w_win_ad;
  logic [7:0]        w_win_din;
  logic [CntW-1:0]   w_cnt_base;
  logic [CntW-1:0]   w_cnt_inc;

  always_comb begin
    w_win = 1'b0;
    if (r_owner_valid && (r_owner_id ? r1_req : r0_req)) begin
      w_win = r_owner_id;
    end else if (r0_req && r1_req) begin
      w_win = ~r_last_winner;
    end else begin
      w_win = r1_req;
    end
    w_grant    = (r0_req | r1_req) & ~arduino_reset;
    w_win_we   = w_win ? r1_we   : r0_we;
    w_win_lock = w_win ? r1_lock : r0_lock;
    w_win_ad   = w_win ? r1_ad   : r0_ad;
    w_win_din  = w_win ? r1_din  : r0_din;
    // A different requester taking the lock starts a fresh burst.
    w_cnt_base = (r_owner_valid && (r_owner_id == w_win)) ? r_burst_cnt : '0;
    w_cnt_inc  = w_cnt_base + CntW'(1);
  end

  assign r0_gnt  = w_grant & ~w_win;
  assign r1_gnt  = w_grant & w_win;
  assign mem_clk = sysclk;
  assign mem_oce = 1'b1;
  assign mem_ce  = w_grant;
  assign mem_wre = w_grant & w_win_we;
  assign mem_ad  = w_grant ? w_win_ad  : r_ad_hold;
  assign mem_din = w_grant ? w_win_din : r_din_hold;

  always_ff @(posedge sysclk) begin
    if (arduino_reset) begin
      r_last_winner <= 1'b1;
      r_owner_valid <= 1'b0;
      r_owner_id    <= 1'b0;
      r_burst_cnt   <= '0;
      r_pipe_vld    <= '0;
      r_pipe_id     <= '0;
    end else begin
      if (w_grant) begin
        r_last_winner <= w_win;
        if (w_win_lock && (w_cnt_inc != BurstMaxC)) begin
          r_owner_valid <= 1'b1;
          r_owner_id    <= w_win;
          r_burst_cnt   <= w_cnt_inc;
        end else begin
          r_owner_valid <= 1'b0;
          r_burst_cnt   <= '0;
        end
      end else begin
        // No grant means nobody requested, so any owner has dropped its request.
        r_owner_valid <= 1'b0;
        r_burst_cnt   <= '0;
      end
      r_pipe_vld[0] <= w_grant & ~w_win_we;
      r_pipe_id[0]  <= w_win;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_grant) begin
      r_ad_hold  <= w_win_ad;
      r_din_hold <= w_win_din;
    end
  end

  assign r0_rvalid = r_pipe_vld[RD_LAT-1] & ~r_pipe_id[RD_LAT-1];
  assign r1_rvalid = r_pipe_vld[RD_LAT-1] & r_pipe_id[RD_LAT-1];
  assign r0_dout   = r0_rvalid ? mem_dout : 8'h00;
  assign r1_dout   = r1_rvalid ? mem_dout : 8'h00;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT 1 and 2) share stimulus and are checked
// every cycle against a queue-based arbitration/return model, plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int unsigned BMAX = 4;

  typedef struct {
    int         due;
    bit         id;
    logic [7:0] data;
  } ret_t;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        rst;
  logic        req [2];
  logic        we  [2];
  logic        lock[2];
  logic [13:0] ad  [2];
  logic [7:0]  din [2];

  logic        g0 [2], g1 [2], rv0 [2], rv1 [2];
  logic [7:0]  do0 [2], do1 [2];
  logic        mclk [2], mce [2], moce [2], mwre [2];
  logic [13:0] mad [2];
  logic [7:0]  mdin [2], mdout [2];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model state
  int         m_last = 1;
  int         m_owner = -1;
  int         m_burst = 0;
  logic [7:0] m_mem [16384];
  logic [13:0] m_ad_hold;
  logic [7:0] m_din_hold;
  bit         hold_known = 1'b0;
  bit         g_model [2];
  ret_t       rq [2][$];

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + (i >> 7));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [7:0] mem_arr [16384];
    logic [7:0] q1, q2;

    mem_port_arbiter #(.RD_LAT(k + 1), .BURST_MAX(BMAX)) u_dut (
      .sysclk(sysclk), .arduino_reset(rst),
      .r0_req(req[0]), .r0_we(we[0]), .r0_lock(lock[0]), .r0_ad(ad[0]), .r0_din(din[0]),
      .r0_gnt(g0[k]), .r0_rvalid(rv0[k]), .r0_dout(do0[k]),
      .r1_req(req[1]), .r1_we(we[1]), .r1_lock(lock[1]), .r1_ad(ad[1]), .r1_din(din[1]),
      .r1_gnt(g1[k]), .r1_rvalid(rv1[k]), .r1_dout(do1[k]),
      .mem_clk(mclk[k]), .mem_ce(mce[k]), .mem_oce(moce[k]), .mem_wre(mwre[k]),
      .mem_ad(mad[k]), .mem_din(mdin[k]), .mem_dout(mdout[k])
    );

    initial for (int i = 0; i < 16384; i++) mem_arr[i] = init_val(i);

    always @(posedge sysclk) begin
      if (mce[k]) begin
        if (mwre[k]) mem_arr[mad[k]] <= mdin[k];
        else         q1 <= mem_arr[mad[k]];
      end
      q2 <= q1;
    end
    assign mdout[k] = (k == 0) ? q1 : q2;
  end

  initial for (int i = 0; i < 16384; i++) m_mem[i] = init_val(i);

  // Compare process: evaluates the model for this cycle, checks, then commits the edge.
  always @(negedge sysclk) begin
    int w;
    bit v0, v1;
    logic [7:0] d;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        v0 = 1'b0; v1 = 1'b0; d = '0;
        if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
          if (rq[k][0].id) v1 = 1'b1; else v0 = 1'b1;
          d = rq[k][0].data;
          void'(rq[k].pop_front());
        end
        chk("rvalid0", rv0[k], v0);
        chk("rvalid1", rv1[k], v1);
        if (v0) chk("dout0", do0[k], d);
        if (v1) chk("dout1", do1[k], d);
      end
    end
    w = -1;
    if (!rst) begin
      if (m_owner >= 0 && req[m_owner]) w = m_owner;
      else if (req[0] && req[1])        w = 1 - m_last;
      else if (req[0])                  w = 0;
      else if (req[1])                  w = 1;
    end
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("gnt0", g0[k], w == 0);
        chk("gnt1", g1[k], w == 1);
        chk("mem_ce", mce[k], w >= 0);
        chk("mem_wre", mwre[k], (w >= 0) ? we[w] : 1'b0);
        chk("mem_oce", moce[k], 1'b1);
        if (w >= 0) begin
          chk("mem_ad", mad[k], ad[w]);
          chk("mem_din", mdin[k], din[w]);
        end else if (hold_known) begin
          chk("mem_ad_hold", mad[k], m_ad_hold);
          chk("mem_din_hold", mdin[k], m_din_hold);
        end
      end
    end
    g_model[0] = (w == 0);
    g_model[1] = (w == 1);
    if (rst) begin
      m_last = 1; m_owner = -1; m_burst = 0;
      rq[0].delete();
      rq[1].delete();
    end else if (w >= 0) begin
      m_last = w;
      if (lock[w]) begin
        m_burst = (m_owner == w) ? m_burst + 1 : 1;
        if (m_burst == int'(BMAX)) begin
          m_owner = -1; m_burst = 0;
        end else begin
          m_owner = w;
        end
      end else begin
        m_owner = -1; m_burst = 0;
      end
      m_ad_hold = ad[w]; m_din_hold = din[w]; hold_known = 1'b1;
      if (we[w]) m_mem[ad[w]] = din[w];
      else begin
        rq[0].push_back('{due: cyc + 1, id: (w == 1), data: m_mem[ad[w]]});
        rq[1].push_back('{due: cyc + 2, id: (w == 1), data: m_mem[ad[w]]});
      end
    end else begin
      m_owner = -1; m_burst = 0;
    end
    cyc++;
  end

  task automatic setr(input int r, input bit rqv, input bit w, input bit lk,
                      input logic [13:0] a, input logic [7:0] dv);
    req[r] = rqv; we[r] = w; lock[r] = lk; ad[r] = a; din[r] = dv;
  endtask

  task automatic idle();
    setr(0, 0, 0, 0, 14'h0, 8'h0);
    setr(1, 0, 0, 0, 14'h0, 8'h0);
  endtask

  task automatic to_obs();
    @(negedge sysclk); #1;
  endtask

  task automatic to_drv();
    @(posedge sysclk); #1;
  endtask

  initial begin
    int lk_seq [7] = '{0, 1, 1, 1, 1, 0, 1};
    bit e_r0 [7]   = '{1, 1, 0, 1, 1, 1, 1};
    bit e_l0 [7]   = '{1, 1, 0, 0, 0, 0, 0};
    bit e_r1 [7]   = '{0, 1, 1, 1, 1, 1, 1};
    bit e_g1 [7]   = '{0, 0, 1, 1, 1, 1, 0};
    logic [13:0] a0, a1;
    bit pend [2];
    rst = 1'b1;
    idle();
    repeat (2) to_drv();
    chk_en = 1'b1;
    to_obs();
    chk("rst_rvalid0", rv0[0], 1'b0);
    chk("rst_rvalid1", rv1[1], 1'b0);
    to_drv();
    rst = 1'b0;

    // Single write then read
    setr(0, 1, 1, 0, 14'h0123, 8'hA5);
    to_obs(); chk("wr_gnt", g0[0], 1'b1);
    to_drv();
    setr(0, 1, 0, 0, 14'h0123, 8'h00);
    to_obs(); chk("rd_gnt", g0[1], 1'b1);
    to_drv(); idle();
    to_obs();
    chk("rd_l1_valid", rv0[0], 1'b1); chk("rd_l1_data", do0[0], 8'hA5);
    chk("rd_l2_early", rv0[1], 1'b0); chk("rd_r1_quiet", rv1[0], 1'b0);
    to_drv();
    to_obs();
    chk("rd_l2_valid", rv0[1], 1'b1); chk("rd_l2_data", do0[1], 8'hA5);
    chk("rd_l1_once", rv0[0], 1'b0);
    to_drv();

    // Contention after reset: strict alternation starting with r0
    rst = 1'b1; to_drv(); to_drv(); rst = 1'b0;
    a0 = 14'h0000; a1 = 14'h3FFD;
    for (int i = 0; i < 6; i++) begin
      setr(0, 1, 0, 0, a0, 8'h00);
      setr(1, 1, 0, 0, a1, 8'h00);
      to_obs();
      chk("cont_g0", g0[0], (i % 2) == 0);
      chk("cont_g1", g1[0], (i % 2) == 1);
      to_drv();
      if (i % 2 == 0) a0 = a0 + 14'd1; else a1 = a1 + 14'd1;
    end
    idle(); to_drv(); to_drv();

    // Locked burst by r1 against a steadily requesting r0
    for (int i = 0; i < 7; i++) begin
      setr(0, 1, 0, 0, 14'h0010, 8'h00);
      setr(1, 1, 0, 1, 14'h0020, 8'h00);
      to_obs();
      chk("lock_g1", g1[0], lk_seq[i] == 1);
      chk("lock_g0", g0[1], lk_seq[i] == 0);
      to_drv();
    end

    // Owner drops req; peer wins same cycle and starts a fresh burst
    for (int i = 0; i < 7; i++) begin
      setr(0, e_r0[i], 0, e_l0[i], 14'h0030, 8'h00);
      setr(1, e_r1[i], 0, 1, 14'h0031, 8'h00);
      to_obs();
      chk("drop_g1", g1[0], e_g1[i]);
      chk("drop_g0", g0[0], e_r0[i] & !e_g1[i]);
      to_drv();
    end
    idle(); to_drv();

    // Write to top address produces no return; following read sees it
    setr(0, 1, 1, 0, 14'h3FFF, 8'h3C);
    to_obs(); chk("top_wr_gnt", g0[0], 1'b1);
    to_drv();
    setr(0, 1, 0, 0, 14'h3FFF, 8'h00);
    to_obs(); chk("top_wr_norv", rv0[0], 1'b0);
    to_drv(); idle();
    to_obs(); chk("top_rd_l1", do0[0], 8'h3C); chk("top_rd_l1_v", rv0[0], 1'b1);
    to_drv();
    to_obs(); chk("top_rd_l2", do0[1], 8'h3C); chk("top_rd_l2_v", rv0[1], 1'b1);
    to_drv();

    // Reset mid-read
    setr(0, 1, 0, 0, 14'h0123, 8'h00);
    to_obs(); chk("mr_gnt", g0[0], 1'b1);
    to_drv();
    rst = 1'b1;
    setr(0, 1, 0, 0, 14'h0002, 8'h00);
    setr(1, 1, 0, 0, 14'h0003, 8'h00);
    to_obs();
    chk("mr_g0_rst", g0[0], 1'b0); chk("mr_g1_rst", g1[1], 1'b0);
    chk("mr_ce0_rst", mce[0], 1'b0); chk("mr_ce1_rst", mce[1], 1'b0);
    to_drv();
    to_obs(); chk("mr_discard", rv0[1], 1'b0);
    to_drv();
    rst = 1'b0;
    to_obs(); chk("mr_first_g0", g0[0], 1'b1); chk("mr_first_g1", g1[0], 1'b0);
    to_drv();
    idle(); to_drv();

    // Randomized traffic with requests held until granted
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] || g_model[r]) begin
          if ($urandom_range(0, 99) < 60) begin
            setr(r, 1, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 14'(14'h3FF8 + $urandom_range(0, 7))
                                             : 14'($urandom_range(0, 15)),
                 8'($urandom));
            pend[r] = 1'b1;
          end else begin
            setr(r, 0, 0, 0, ad[r], din[r]);
            pend[r] = 1'b0;
          end
        end
      end
      rst = ($urandom_range(0, 249) == 0);
      to_drv();
    end
    rst = 1'b0; idle();
    repeat (3) to_drv();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
